mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: one word-addressed RAM behind a valid/ready
// request/response pair. Define MEM_RESPONDER_BE_EN to enable per-byte store enables.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef MEM_RESPONDER_BE_EN
    logic [3:0]  be;
`endif
  } req_t;

  state_t        state, nxt;
  logic [3:0]    cnt;
  req_t          cap, cur;
  logic [31:0]   mem [DEPTH];
  logic          accept, commit, fault;
  logic [AW-1:0] idx;

  assign accept = (state == IDLE) && req_valid;
  // Work for the edge entering RESP; with zero wait states that is the accept edge itself.
  assign commit = (nxt == RESP) && (state != RESP);

  // In IDLE the live request is used directly so the zero-wait path needs no extra cycle.
  always_comb begin
    cur = cap;
    if (state == IDLE) begin
      cur.we    = req_we;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
`ifdef MEM_RESPONDER_BE_EN
      cur.be    = req_be;
`endif
    end
  end

`ifndef MEM_RESPONDER_BE_EN
  logic unused_be;
  assign unused_be = ^req_be;
`endif

  assign fault = (cur.addr[1:0] != 2'b00) || (cur.addr[31:2] >= 30'(DEPTH));
  assign idx   = cur.addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (req_valid) nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cnt == 4'd0) nxt = RESP;
      RESP: if (rsp_ready)   nxt = IDLE;
      default:               nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 4'd0;
      cap <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
      cap <= cur;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= fault;
      rsp_rdata <= (fault || cur.we) ? 32'd0 : mem[idx];
    end
  end

  // Storage is never reset; a store aborted by reset never reaches this commit.
  always_ff @(posedge clk) begin
    if (rst && commit && cur.we && !fault) begin
`ifdef MEM_RESPONDER_BE_EN
      for (int b = 0; b < 4; b++)
        if (cur.be[b]) mem[idx][8*b +: 8] <= cur.wdata[8*b +: 8];
`else
      mem[idx] <= cur.wdata;
`endif
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: a DEPTH=256/WAIT_CYCLES=2 instance plus a DEPTH=16/WAIT_CYCLES=0 instance.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_be = 4'hF;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 0, z_req_we = 0, z_rsp_ready = 0;
  logic [31:0] z_req_addr = 0, z_req_wdata = 0;
  logic [3:0]  z_req_be = 4'hF;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int n_cmp = 0, n_fail = 0;

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

  // One transaction on the main instance. lat = edges after the accept edge until
  // rsp_valid is seen; 40 means the response never came.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 0; req_we = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if (z_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_z_req_ready got %b want 1", z_req_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL st_latency got %0d want 2", lat); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL st_err got %b want 0", er); end
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL st_rdata got %h want 0", rd); end
    txn(0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL ld_latency got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_rdata got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b want 0", er); end
  endtask

  task automatic test_patterns();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addrs [4] = '{32'h0, 32'h3FC, 32'h4, 32'h80};
    logic [31:0] vals  [4] = '{32'h1122_3344, 32'hA5A5_5A5A, 32'h0, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) txn(1, addrs[i], vals[i], 4'hF, rd, er, lat);
    for (int i = 0; i < 4; i++) begin
      txn(0, addrs[i], 32'h0, 4'hF, rd, er, lat);
      n_cmp++; if (rd !== vals[i] || er !== 1'b0)
        begin n_fail++; $display("FAIL pattern_%0d got %h/%b want %h/0", i, rd, er, vals[i]); end
    end
  endtask

  task automatic test_fault();
    logic [31:0] rd; logic er; int lat;
    txn(0, 32'h6, 32'h0, 4'hF, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_ld got %h/%b want 0/1", rd, er); end
    txn(0, 32'h400, 32'h0, 4'hF, rd, er, lat);
    n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL oob_ld got %h/%b want 0/1", rd, er); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL oob_latency got %0d want 2", lat); end
    txn(1, 32'h400, 32'hFFFF_0000, 4'hF, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL oob_st_err got %b want 1", er); end
    txn(1, 32'h2, 32'h0BAD_0BAD, 4'hF, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL mis_st_err got %b want 1", er); end
    txn(0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    n_cmp++; if (rd !== 32'h1122_3344 || er !== 1'b0) begin n_fail++; $display("FAIL word0_intact got %h want 11223344", rd); end
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'h0BAD_F00D; end
      else        req_valid = 0;
      @(posedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || req_ready !== 1'b0)
        begin n_fail++; $display("FAIL stall_c%0d got v=%b d=%h e=%b r=%b want 1/deadbeef/0/0", c, rsp_valid, rsp_rdata, rsp_err, req_ready); end
    end
    req_valid = 0; req_we = 0;
    rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got r=%b v=%b want 1/0", req_ready, rsp_valid); end
    // rsp_ready asserted while idle must not start or complete anything
    rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_rsp_ready got v=%b r=%b want 0/1", rsp_valid, req_ready); end
    txn(0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_ignored_st got %h want deadbeef", rd); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat;
    txn(1, 32'h20, 32'h1234_5678, 4'hF, rd, er, lat);
    txn(0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 0; req_we = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_state got v=%b r=%b want 0/1", rsp_valid, req_ready); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rstwait_rdata got %h want 0", rsp_rdata); end
    @(negedge clk); rst = 1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_no_rsp got %b want 0", rsp_valid); end
    txn(0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rstwait_mem got %h want 12345678", rd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat;
    txn(1, 32'h0, 32'h1122_3344, 4'hF, rd, er, lat);
    txn(1, 32'h0, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    txn(0, 32'h0, 32'h0, 4'hF, rd, er, lat);
`ifdef MEM_RESPONDER_BE_EN
    n_cmp++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL be_merge got %h want 11bb33dd", rd); end
    txn(1, 32'h0, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    n_cmp++; if (er !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL be_zero_complete got e=%b lat=%0d want 0/2", er, lat); end
    txn(0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    n_cmp++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL be_zero_noop got %h want 11bb33dd", rd); end
`else
    n_cmp++; if (rd !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL be_ignored got %h want aabbccdd", rd); end
`endif
  endtask

  task automatic test_zero_wait();
    logic [31:0] wvals [2] = '{32'h600D_CAFE, 32'h0};
    logic [31:0] want_d;
    logic        want_e;
    int lat;
    // store, load, out-of-range load (4*DEPTH = 0x40)
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      z_req_valid = 1; z_req_we = (t == 0); z_req_wdata = wvals[0];
      z_req_addr  = (t == 2) ? 32'h40 : 32'h8;
      @(posedge clk); #1;
      z_req_valid = 0;
      lat = 0;
      while (!z_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      want_d = (t == 1) ? wvals[0] : wvals[1];
      want_e = (t == 2);
      n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL z_latency_%0d got %0d want 0", t, lat); end
      n_cmp++; if (z_rsp_rdata !== want_d || z_rsp_err !== want_e)
        begin n_fail++; $display("FAIL z_data_%0d got %h/%b want %h/%b", t, z_rsp_rdata, z_rsp_err, want_d, want_e); end
      n_cmp++; if (z_req_ready !== 1'b0) begin n_fail++; $display("FAIL z_ready_in_resp_%0d got %b want 0", t, z_req_ready); end
      z_req_valid = 1; z_rsp_ready = 1;
      @(posedge clk); #1;
      z_rsp_ready = 0; z_req_valid = 0;
      n_cmp++; if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0)
        begin n_fail++; $display("FAIL z_after_hs_%0d got r=%b v=%b want 1/0", t, z_req_ready, z_rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_patterns();
    test_fault();
    test_stall();
    test_reset_in_wait();
    test_byte_enable();
    test_zero_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
